// File: rtl/sample_ram_arbiter.sv
// Purpose : arbitrate one single-port sample RAM between the audio writer, effects reader and VGA reader.
// Latency : grant is combinational; RAM command registered one cycle after grant; read data valid two cycles after grant.
// Backpres: no queuing; a requester holds req/addr/data until its gnt is high, and the writer always wins.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   w_req/w_addr/w_data/w_gnt   audio writer request and grant
//   e_req/e_addr/e_gnt          effects reader request and grant; e_rvalid/e_rdata return path
//   v_req/v_addr/v_gnt          display reader request and grant; v_rvalid/v_rdata return path
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   synchronous single-port RAM port
//   conflict_cnt                saturating count of cycles with two or more requests pending
//
// Build option: define SAMPLE_ARB_RR_EN for round-robin between the two readers
// (effects first after reset); otherwise readers use fixed priority effects > display.
module sample_ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  w_req,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_gnt,

    input  logic                  e_req,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] e_rdata,

    input  logic                  v_req,
    input  logic [ADDR_WIDTH-1:0] v_addr,
    output logic                  v_gnt,
    output logic                  v_rvalid,
    output logic [DATA_WIDTH-1:0] v_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [15:0]           conflict_cnt
);

    // Owner tag of the read command currently on the RAM port.
    logic       rd_e_q;
    logic       rd_v_q;
    logic [1:0] req_cnt;

`ifdef SAMPLE_ARB_RR_EN
    // 0: effects is preferred on a tie, 1: display is preferred.
    logic       rr_ptr;
`endif

    always_comb begin
        w_gnt = 1'b0;
        e_gnt = 1'b0;
        v_gnt = 1'b0;
        if (!reset) begin
            if (w_req) begin
                w_gnt = 1'b1;
            end else if (e_req && v_req) begin
`ifdef SAMPLE_ARB_RR_EN
                if (rr_ptr) begin
                    v_gnt = 1'b1;
                end else begin
                    e_gnt = 1'b1;
                end
`else
                e_gnt = 1'b1;
`endif
            end else if (e_req) begin
                e_gnt = 1'b1;
            end else if (v_req) begin
                v_gnt = 1'b1;
            end
        end
    end

    assign req_cnt = {1'b0, w_req} + {1'b0, e_req} + {1'b0, v_req};

    // The RAM returns data one cycle after the command, so both readers see it
    // directly; rvalid alone tells the owner when it is theirs.
    assign e_rdata = mem_rdata;
    assign v_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rd_e_q       <= 1'b0;
            rd_v_q       <= 1'b0;
            e_rvalid     <= 1'b0;
            v_rvalid     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            mem_en <= w_gnt | e_gnt | v_gnt;
            mem_we <= w_gnt;
            if (w_gnt) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_data;
            end else if (e_gnt) begin
                mem_addr  <= e_addr;
            end else if (v_gnt) begin
                mem_addr  <= v_addr;
            end

            // Two-stage tag pipeline: command cycle, then data-return cycle.
            rd_e_q   <= e_gnt;
            rd_v_q   <= v_gnt;
            e_rvalid <= rd_e_q;
            v_rvalid <= rd_v_q;

            if (req_cnt >= 2'd2 && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

`ifdef SAMPLE_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (e_gnt) begin
            rr_ptr <= 1'b1;
        end else if (v_gnt) begin
            rr_ptr <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sample_ram_arbiter.sv
// Purpose : directed self-checking bench for sample_ram_arbiter with a behavioural synchronous RAM.
// Latency : checks grant same cycle, RAM command next cycle, read data two cycles after grant.
// Backpres: requests are held by the bench until granted; no flow control beyond that.
module tb_sample_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_req, e_req, v_req;
    logic [AW-1:0] w_addr, e_addr, v_addr;
    logic [DW-1:0] w_data;
    logic          w_gnt, e_gnt, v_gnt;
    logic          e_rvalid, v_rvalid;
    logic [DW-1:0] e_rdata, v_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    int n_chk = 0;
    int n_bad = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #10 clk = ~clk;

    sample_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .e_req(e_req), .e_addr(e_addr), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Synchronous single-port RAM: read data one cycle after the command.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        w_req = 1'b0; e_req = 1'b0; v_req = 1'b0;
        w_addr = '0; e_addr = '0; v_addr = '0; w_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".gnt"},    {29'd0, w_gnt, e_gnt, v_gnt}, 32'd0);
        chk({tag, ".rvalid"}, {30'd0, e_rvalid, v_rvalid}, 32'd0);
        chk({tag, ".en_we"},  {30'd0, mem_en, mem_we}, 32'd0);
        chk({tag, ".addr"},   {20'd0, mem_addr}, 32'd0);
        chk({tag, ".wdata"},  {16'd0, mem_wdata}, 32'd0);
        chk({tag, ".cnt"},    {16'd0, conflict_cnt}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        mem_rdata = '0;

        // Reset: grants forced low even with a writer request.
        reset = 1'b1;
        w_req = 1'b1; w_addr = 12'h0AA; w_data = 16'hDEAD;
        settle();
        chk("rst_wgnt_forced", {31'd0, w_gnt}, 32'd0);
        step();
        step();
        idle_inputs();
        reset = 1'b0;
        settle();
        chk_reset_vals("reset");

        // Write 0x1234 to 0x010.
        w_req = 1'b1; w_addr = 12'h010; w_data = 16'h1234;
        settle();
        chk("wr.gnt", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b100);
        step();
        idle_inputs();
        chk("wr.en_we", {30'd0, mem_en, mem_we}, 32'b11);
        chk("wr.addr",  {20'd0, mem_addr}, 32'h010);
        chk("wr.wdata", {16'd0, mem_wdata}, 32'h1234);

        // Effects read of 0x010.
        e_req = 1'b1; e_addr = 12'h010;
        settle();
        chk("rd.gnt", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b010);
        step();
        idle_inputs();
        chk("rd.cmd", {30'd0, mem_en, mem_we}, 32'b10);
        chk("rd.addr", {20'd0, mem_addr}, 32'h010);
        chk("rd.early", {30'd0, e_rvalid, v_rvalid}, 32'b00);
        step();
        chk("rd.rvalid", {30'd0, e_rvalid, v_rvalid}, 32'b10);
        chk("rd.rdata", {16'd0, e_rdata}, 32'h1234);
        step();
        chk("rd.once", {30'd0, e_rvalid, v_rvalid}, 32'b00);
        chk("idle.en", {31'd0, mem_en}, 32'd0);

        // Write then immediate display read of same address, then effects read back-to-back.
        w_req = 1'b1; w_addr = 12'h030; w_data = 16'h5555;
        settle();
        chk("raw.wgnt", {31'd0, w_gnt}, 32'd1);
        step();
        idle_inputs();
        v_req = 1'b1; v_addr = 12'h030;
        settle();
        chk("raw.vgnt", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b001);
        step();
        idle_inputs();
        e_req = 1'b1; e_addr = 12'h010;
        settle();
        chk("b2b.egnt", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b010);
        chk("b2b.vcmd", {19'd0, mem_en, mem_we, mem_addr}, {19'd0, 1'b1, 1'b0, 12'h030});
        step();
        idle_inputs();
        chk("b2b.v_rv", {30'd0, e_rvalid, v_rvalid}, 32'b01);
        chk("b2b.v_dat", {16'd0, v_rdata}, 32'h5555);
        step();
        chk("b2b.e_rv", {30'd0, e_rvalid, v_rvalid}, 32'b10);
        chk("b2b.e_dat", {16'd0, e_rdata}, 32'h1234);
        step();
        chk("b2b.done", {30'd0, e_rvalid, v_rvalid}, 32'b00);

        // All three requesting for 4 cycles: writer wins every cycle.
        do_reset();
        settle();
        w_req = 1'b1; e_req = 1'b1; v_req = 1'b1;
        w_addr = 12'h100; e_addr = 12'h200; v_addr = 12'h300; w_data = 16'h0F0F;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("all3.gnt%0d", i), {29'd0, w_gnt, e_gnt, v_gnt}, 32'b100);
            step();
        end
        idle_inputs();
        chk("all3.cnt", {16'd0, conflict_cnt}, 32'd4);

        // Both readers held for 6 cycles.
        do_reset();
        settle();
        e_req = 1'b1; v_req = 1'b1; e_addr = 12'h010; v_addr = 12'h030;
        for (int i = 0; i < 6; i++) begin
            settle();
`ifdef SAMPLE_ARB_RR_EN
            chk($sformatf("rd2.gnt%0d", i), {29'd0, w_gnt, e_gnt, v_gnt},
                (i % 2 == 0) ? 32'b010 : 32'b001);
`else
            chk($sformatf("rd2.gnt%0d", i), {29'd0, w_gnt, e_gnt, v_gnt}, 32'b010);
`endif
            step();
        end
        idle_inputs();
        chk("rd2.cnt", {16'd0, conflict_cnt}, 32'd6);

        // Read granted, then reset for one cycle: the read is squashed.
        step();
        step();
        e_req = 1'b1; e_addr = 12'h010;
        settle();
        chk("sq.egnt", {31'd0, e_gnt}, 32'd1);
        step();
        idle_inputs();
        reset = 1'b1;
        v_req = 1'b1; v_addr = 12'h030;
        settle();
        chk("sq.gnt_forced", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b000);
        step();
        idle_inputs();
        reset = 1'b0;
        settle();
        chk_reset_vals("sq");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sq.no_rv%0d", i), {30'd0, e_rvalid, v_rvalid}, 32'b00);
        end

        // Counter saturation after 0x10005 conflicting cycles.
        e_req = 1'b1; v_req = 1'b1;
        repeat (32'h10005) step();
        chk("sat.cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
        idle_inputs();
        step();
        chk("sat.hold", {16'd0, conflict_cnt}, 32'h0000FFFF);
        chk("sat.idle_gnt", {29'd0, w_gnt, e_gnt, v_gnt}, 32'b000);
        step();
        chk("sat.idle_en", {31'd0, mem_en}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
